alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_defs_pkg.sv | 26 ++
 rtl/alu_core.sv | 62 ++++++
 rtl/alu_exec_unit.sv | 102 ++++++++++
 tb/tb_alu_exec_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU execution unit.
//   ALU_WIDTH        default operand/result width
//   FLAG_V..FLAG_Z   bit positions inside the 4-bit status word {V,C,N,Z}
//   alu_op_e         operation-select encodings; any other code is illegal
package alu_defs;

  localparam int unsigned ALU_WIDTH = 64;

  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [4:0] {
    OP_PASSA = 5'b00000,
    OP_ADD   = 5'b10000,
    OP_SUB   = 5'b10001,
    OP_AND   = 5'b10100,
    OP_OR    = 5'b00100,
    OP_XOR   = 5'b01100,
    OP_NOTA  = 5'b01110,
    OP_SHL   = 5'b11000,
    OP_SHR   = 5'b11001
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
//   a, b    operands
//   cin     carry-in (used by ADD/SUB only)
//   sel     operation select (alu_op_e encodings)
//   result  operation result (0 for illegal sel)
//   status  {V,C,N,Z}
//   err     sel is not a legal encoding
module alu_core
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [4:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status,
  output logic             err
);

  localparam int unsigned      SHW   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SHLIM = WIDTH'(WIDTH);

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             arith;
  logic             big_sh;

  always_comb begin
    // SUB shares the adder: A + ~B + cin
    b_op   = (sel == OP_SUB) ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    // the whole B operand sets the shift amount, so any B >= WIDTH clears the result
    big_sh = (b >= SHLIM);
    result = '0;
    err    = 1'b0;
    arith  = 1'b0;
    case (sel)
      OP_PASSA: result = a;
      OP_ADD, OP_SUB: begin
        result = sum[WIDTH-1:0];
        arith  = 1'b1;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOTA: result = ~a;
      OP_SHL:  result = big_sh ? '0 : (a << b[SHW-1:0]);
      OP_SHR:  result = big_sh ? '0 : (a >> b[SHW-1:0]);
      default: err = 1'b1;
    endcase

    status         = '0;
    status[FLAG_Z] = (result == '0);
    status[FLAG_N] = result[WIDTH-1];
    status[FLAG_C] = arith & sum[WIDTH];
    // signed overflow: operands agree in sign but the result does not
    status[FLAG_V] = arith & (a[WIDTH-1] == b_op[WIDTH-1]) & (result[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        request handshake
//   in_a, in_b, in_cin, in_sel  request operands and operation select
//   out_valid/out_ready      response handshake
//   out_result, out_status   result and {V,C,N,Z} flags
//   out_err                  illegal operation select was received
//   op_count                 number of completed output handshakes (wraps)
module alu_exec_unit
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [4:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_status,
  output logic             out_err,
  output logic [15:0]      op_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [4:0]       s1_sel;

  logic [WIDTH-1:0] c_result;
  logic [3:0]       c_status;
  logic             c_err;

  logic s2_load;
  logic accept;

  // S1 empties whenever S2 can take it, so in_ready looks through to out_ready
  always_comb begin
    s2_load  = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || s2_load;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_sel   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_cin   <= in_cin;
      s1_sel   <= in_sel;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .cin    (s1_cin),
    .sel    (s1_sel),
    .result (c_result),
    .status (c_status),
    .err    (c_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_status <= '0;
      out_err    <= 1'b0;
    end else if (s2_load) begin
      out_valid  <= 1'b1;
      out_result <= c_result;
      out_status <= c_status;
      out_err    <= c_err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: accepted requests push a model response,
// a monitor compares every presented response against the queue head.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic [4:0]  in_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [3:0]  out_status;
  logic        out_err;
  logic [15:0] op_count;

  int unsigned nvec = 0;
  int unsigned nfail = 0;
  logic [68:0] exp_q[$];
  logic [15:0] cnt = '0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_status(out_status), .out_err(out_err), .op_count(op_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {err, V, C, N, Z, result} from the operation definitions
  function automatic logic [68:0] model(input logic [4:0] sel, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin);
    logic [63:0] r, bb;
    logic [64:0] u;
    logic signed [65:0] ssum;
    logic c, v, e;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (sel)
      5'b00000: r = a;
      5'b10000, 5'b10001: begin
        bb   = (sel == 5'b10001) ? ~b : b;
        u    = {1'b0, a} + {1'b0, bb} + {64'd0, cin};
        r    = u[63:0];
        c    = u[64];
        ssum = $signed({{2{a[63]}}, a}) + $signed({{2{bb[63]}}, bb}) + $signed({65'd0, cin});
        v    = (ssum > 66'sh07FFFFFFFFFFFFFFF) || (ssum < -66'sh08000000000000000);
      end
      5'b10100: r = a & b;
      5'b00100: r = a | b;
      5'b01100: r = a ^ b;
      5'b01110: r = ~a;
      5'b11000: r = (b >= 64) ? 64'd0 : a << b;
      5'b11001: r = (b >= 64) ? 64'd0 : a >> b;
      default:  e = 1'b1;
    endcase
    return {e, v, c, r[63], (r == 64'd0), r};
  endfunction

  // Monitor: handshakes are sampled just before each rising edge
  initial begin
    logic [68:0] h;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        chk("op_count", {48'd0, op_count}, {48'd0, cnt});
        if (in_valid && in_ready)
          exp_q.push_back(model(in_sel, in_a, in_b, in_cin));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_response", 64'd1, 64'd0);
          end else begin
            h = exp_q[0];
            chk("result", out_result, h[63:0]);
            chk("status", {60'd0, out_status}, {60'd0, h[67:64]});
            chk("err", {63'd0, out_err}, {63'd0, h[68]});
            if (out_ready) begin
              void'(exp_q.pop_front());
              cnt = cnt + 16'd1;
            end
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [4:0] sel, input logic [63:0] a, input logic [63:0] b,
                      input logic cin);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; in_sel = sel; in_a = a; in_b = b; in_cin = cin;
    for (int t = 0; t < 200; t++) begin
      #4;
      got = in_ready;
      @(negedge clk);
      if (got) break;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int unsigned lim);
    for (int unsigned t = 0; t < lim && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    exp_q.delete();
    cnt = '0;
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_op_count", {48'd0, op_count}, 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_status", {60'd0, out_status}, 64'd0);
    chk("rst_err", {63'd0, out_err}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [4:0] legal[9];
    logic [4:0] s;
    logic [63:0] ra, rb;
    legal = '{5'b00000, 5'b10000, 5'b10001, 5'b10100, 5'b00100,
              5'b01100, 5'b01110, 5'b11000, 5'b11001};

    // reset state (sampled after clock edges while held in reset)
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    #1 chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // ADD 2+2 and the two-edge latency
    send(5'b10000, 64'd2, 64'd2, 1'b0);
    chk("lat_edge1_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_edge2_out_valid", {63'd0, out_valid}, 64'd1);
    chk("add_2_2", out_result, 64'd4);
    chk("add_2_2_status", {60'd0, out_status}, 64'd0);

    send(5'b10001, 64'd2, 64'd4, 1'b1);
    send(5'b10000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    send(5'b10000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    send(5'b11000, 64'd2, 64'd3, 1'b1);
    send(5'b11001, 64'd2, 64'd64, 1'b0);
    send(5'b11111, 64'd5, 64'd6, 1'b1);
    send(5'b01110, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b1);
    wait_empty(20);

    // backpressure
    assert_reset();
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    send(5'b10100, 64'd2, 64'd1, 1'b0);
    send(5'b00100, 64'd3, 64'd4, 1'b0);
    chk("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
    repeat (3) @(negedge clk);
    chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_hold_result", out_result, 64'd0);
    out_ready = 1'b1;
    send(5'b01100, 64'd2, 64'd5, 1'b0);
    wait_empty(20);
    @(negedge clk);
    chk("bp_op_count", {48'd0, op_count}, 64'd3);

    // randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) s = 5'($urandom);
      else s = legal[$urandom_range(0, 8)];
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ra = 64'h7FFF_FFFF_FFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = ra;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sel = s; in_a = ra; in_b = rb; in_cin = 1'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty(20);

    // reset with two operations in flight
    out_ready = 1'b0;
    send(5'b10000, 64'd10, 64'd20, 1'b0);
    send(5'b10000, 64'd30, 64'd40, 1'b0);
    assert_reset();
    #1 check_reset_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_after_midreset", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_stale_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_op_count", {48'd0, op_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
